// File: rtl/rgb_breathe.sv
// Single-channel-at-a-time RGB breathing driver: ramps a PWM duty up and down
// on red, then green, then blue, advancing one step per accepted tick.
module rgb_breathe #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic en,
  output logic RGB0,
  output logic RGB1,
  output logic RGB2,
  output logic cycle_done
);

  localparam int unsigned   W      = PWM_BITS;
  localparam logic [W-1:0]  MAX    = {W{1'b1}};
  localparam logic [W:0]    STEP_W = (W+1)'(STEP);

  typedef enum logic [2:0] {R_UP, R_DN, G_UP, G_DN, B_UP, B_DN} state_t;

  // Initialisers match the reset values so power-up without reset is safe.
  state_t       state   = R_UP;
  logic [W-1:0] pwm_ctr = '0;
  logic [W-1:0] level   = '0;
  logic [2:0]   rgb_q   = 3'b111;
  logic         done_q  = 1'b0;

  logic         accept;
  logic         is_up;
  logic         pwm_on;
  logic [W:0]   up_sum;
  logic [2:0]   color;
  state_t       peak_st;
  state_t       floor_st;

  // Per-state decode: active colour, ramp direction and the two exit states.
  always_comb begin
    accept   = tick & en;
    up_sum   = {1'b0, level} + STEP_W;
    pwm_on   = pwm_ctr < level;
    is_up    = 1'b0;
    color    = 3'b001;
    peak_st  = state;
    floor_st = state;
    unique case (state)
      R_UP: begin is_up = 1'b1; peak_st = R_DN; end
      R_DN: begin floor_st = G_UP; end
      G_UP: begin is_up = 1'b1; color = 3'b010; peak_st = G_DN; end
      G_DN: begin color = 3'b010; floor_st = B_UP; end
      B_UP: begin is_up = 1'b1; color = 3'b100; peak_st = B_DN; end
      B_DN: begin color = 3'b100; floor_st = R_UP; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= R_UP;
      pwm_ctr <= '0;
      level   <= '0;
      rgb_q   <= 3'b111;
      done_q  <= 1'b0;
    end else begin
      pwm_ctr <= pwm_ctr + W'(1);
      done_q  <= 1'b0;
      rgb_q   <= en ? ~(color & {3{pwm_on}}) : 3'b111;
      if (accept) begin
        if (is_up) begin
          if (up_sum < {1'b0, MAX}) begin
            level <= up_sum[W-1:0];
          end else begin
            level <= MAX;
            state <= peak_st;
          end
        end else if ({1'b0, level} > STEP_W) begin
          level <= level - STEP_W[W-1:0];
        end else begin
          level  <= '0;
          state  <= floor_st;
          done_q <= (state == B_DN);
        end
      end
    end
  end

  assign RGB0       = rgb_q[0];
  assign RGB1       = rgb_q[1];
  assign RGB2       = rgb_q[2];
  assign cycle_done = done_q;

endmodule

// File: tb/tb_rgb_breathe.sv
// Bench for rgb_breathe: two instances (STEP=1 and STEP=100) share stimulus and
// are checked every cycle against an arithmetic model, plus directed literals.
module tb_rgb_breathe;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic tick = 1'b0;
  logic en   = 1'b0;

  logic a_r0, a_r1, a_r2, a_done;
  logic b_r0, b_r1, b_r2, b_done;

  rgb_breathe #(.PWM_BITS(8), .STEP(1)) u0 (
    .clk(clk), .rst(rst), .tick(tick), .en(en),
    .RGB0(a_r0), .RGB1(a_r1), .RGB2(a_r2), .cycle_done(a_done)
  );

  rgb_breathe #(.PWM_BITS(8), .STEP(100)) u1 (
    .clk(clk), .rst(rst), .tick(tick), .en(en),
    .RGB0(b_r0), .RGB1(b_r1), .RGB2(b_r2), .cycle_done(b_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] dut_rgb(input int k);
    return (k == 0) ? {a_r2, a_r1, a_r0} : {b_r2, b_r1, b_r0};
  endfunction

  function automatic logic dut_done(input int k);
    return (k == 0) ? a_done : b_done;
  endfunction

  function automatic int dut_level(input int k);
    return (k == 0) ? int'(u0.level) : int'(u1.level);
  endfunction

  // Behavioural model: colour index 0..2, direction flag, plain integer level.
  localparam int MAXV = 255;
  int         stp   [2] = '{1, 100};
  int         m_ctr [2] = '{0, 0};
  int         m_lvl [2] = '{0, 0};
  int         m_col [2] = '{0, 0};
  bit         m_up  [2] = '{1'b1, 1'b1};
  logic [2:0] m_rgb [2] = '{3'b111, 3'b111};
  logic       m_done[2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_ctr[k] = 0; m_lvl[k] = 0; m_col[k] = 0; m_up[k] = 1'b1;
        m_rgb[k] = 3'b111; m_done[k] = 1'b0;
      end else begin
        m_rgb[k] = 3'b111;
        if (en && (m_ctr[k] < m_lvl[k])) m_rgb[k][m_col[k]] = 1'b0;
        m_done[k] = 1'b0;
        if (tick && en) begin
          if (m_up[k]) begin
            if (m_lvl[k] + stp[k] >= MAXV) begin
              m_lvl[k] = MAXV; m_up[k] = 1'b0;
            end else begin
              m_lvl[k] = m_lvl[k] + stp[k];
            end
          end else if (m_lvl[k] <= stp[k]) begin
            m_lvl[k] = 0; m_up[k] = 1'b1;
            if (m_col[k] == 2) m_done[k] = 1'b1;
            m_col[k] = (m_col[k] + 1) % 3;
          end else begin
            m_lvl[k] = m_lvl[k] - stp[k];
          end
        end
        m_ctr[k] = (m_ctr[k] + 1) % 256;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rgb[%0d]", k), int'(dut_rgb(k)), int'(m_rgb[k]));
      check($sformatf("cycle_done[%0d]", k), int'(dut_done(k)), int'(m_done[k]));
      check($sformatf("level[%0d]", k), dut_level(k), m_lvl[k]);
    end
  end

  int low_cnt [2][3];
  int done_cnt[2];

  task automatic clear_meas();
    for (int k = 0; k < 2; k++) begin
      done_cnt[k] = 0;
      for (int c = 0; c < 3; c++) low_cnt[k][c] = 0;
    end
  endtask

  // One clock: sample outputs just after the falling edge, then inputs may change.
  task automatic step();
    logic [2:0] v;
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      v = dut_rgb(k);
      for (int c = 0; c < 3; c++) if (!v[c]) low_cnt[k][c]++;
      if (dut_done(k)) done_cnt[k]++;
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_ticks(input int n);
    repeat (n) begin
      tick = 1'b1; step();
      tick = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; run(2); rst = 1'b1;
  endtask

  int exp100[6] = '{100, 200, 255, 155, 55, 0};

  initial begin
    // Idle after reset: level 0 must never light anything.
    do_reset();
    en = 1'b1;
    clear_meas();
    run(1000);
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) check($sformatf("idle_low[%0d][%0d]", k, c), low_cnt[k][c], 0);
      check($sformatf("idle_done[%0d]", k), done_cnt[k], 0);
    end

    // STEP=100 ramp through red and into green.
    for (int i = 0; i < 6; i++) begin
      pulse_ticks(1);
      check($sformatf("lvl100_t%0d", i + 1), dut_level(1), exp100[i]);
      check($sformatf("model100_t%0d", i + 1), m_lvl[1], exp100[i]);
    end
    check("model100_green", m_col[1], 1);

    // Twelve more ticks complete the 18-tick sequence exactly once.
    clear_meas();
    pulse_ticks(12);
    run(2);
    check("done_pulses_step100", done_cnt[1], 1);
    check("done_pulses_step1", done_cnt[0], 0);
    check("lvl100_after18", dut_level(1), 0);
    check("model100_red", m_col[1], 0);

    // 128 ticks at STEP=1 gives a 128/256 red duty.
    do_reset();
    tick = 1'b1; run(128); tick = 1'b0;
    run(1);
    check("lvl_128", dut_level(0), 128);
    clear_meas();
    run(256);
    check("duty128_red", low_cnt[0][0], 128);
    check("duty128_green", low_cnt[0][1], 0);
    check("duty128_blue", low_cnt[0][2], 0);

    // Freeze at level 40 with ticks present, then resume.
    do_reset();
    tick = 1'b1; run(40); tick = 1'b0;
    check("lvl_40", dut_level(0), 40);
    en = 1'b0; tick = 1'b1;
    clear_meas();
    run(50);
    tick = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 3; c++) check($sformatf("frozen_low[%0d][%0d]", k, c), low_cnt[k][c], 0);
    check("frozen_lvl", dut_level(0), 40);
    check("frozen_model", m_lvl[0], 40);
    en = 1'b1;
    run(1);
    clear_meas();
    run(256);
    check("resume_duty40", low_cnt[0][0], 40);

    // Reach G_DN at 77, then reset with a coincident tick.
    do_reset();
    tick = 1'b1; run(943); tick = 1'b0;
    check("gdn_lvl", dut_level(0), 77);
    check("gdn_model_col", m_col[0], 1);
    check("gdn_model_dir", int'(m_up[0]), 0);
    rst = 1'b0; tick = 1'b1;
    step();
    rst = 1'b1; tick = 1'b0;
    check("rst_rgb", int'(dut_rgb(0)), 3'b111);
    check("rst_lvl", dut_level(0), 0);
    check("rst_model_col", m_col[0], 0);

    // Randomised traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      rst  = ($urandom % 300) != 0;
      en   = ($urandom % 8) != 0;
      tick = ($urandom % 3) == 0;
      step();
    end
    rst = 1'b1; en = 1'b0; tick = 1'b0;
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_breathe.md
RGB_BREATHE -- requirements
Module: rgb_breathe

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8: width of the PWM counter and the duty level.
REQ-002 SHALL have parameter STEP, default 1: duty increment/decrement applied per accepted tick; legal range 1..2^PWM_BITS-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port tick, input, 1 bit: active-high single-cycle strobe from the upstream period counter; one strobe advances the breathing ramp by one step.
REQ-006 SHALL have port en, input, 1 bit: high = run; low = freeze ramp and force all LEDs off.
REQ-007 SHALL have ports RGB0, RGB1, RGB2, output, 1 bit each, registered: active-low drive for red, green and blue; 1 = LED off.
REQ-008 SHALL have port cycle_done, output, 1 bit, registered: one-cycle high pulse when a full red-green-blue breathing sequence completes.

Function
REQ-009 SHALL keep a free-running PWM_BITS-wide pwm_ctr that increments every clk, wraps from 2^PWM_BITS-1 to 0, and is independent of en and tick.
REQ-010 SHALL keep a PWM_BITS-wide duty register named level, plus a 6-state FSM: R_UP, R_DN, G_UP, G_DN, B_UP, B_DN.
REQ-011 SHALL treat a tick as accepted only on a cycle where tick=1 and en=1; all other ticks are ignored and leave no pending effect.
REQ-012 SHALL, on an accepted tick in an *_UP state with level+STEP < MAX (MAX=2^PWM_BITS-1), set level <= level+STEP and keep the state.
REQ-013 SHALL, on an accepted tick in an *_UP state with level+STEP >= MAX, set level <= MAX and move to the matching *_DN state; the sum is evaluated one bit wider, so no overflow is possible.
REQ-014 SHALL, on an accepted tick in a *_DN state with level > STEP, set level <= level-STEP and keep the state.
REQ-015 SHALL, on an accepted tick in a *_DN state with level <= STEP, set level <= 0 and transition R_DN->G_UP, G_DN->B_UP, or B_DN->R_UP.
REQ-016 SHALL pulse cycle_done high for exactly the cycle after the accepted tick that causes B_DN->R_UP, and hold it low otherwise.
REQ-017 SHALL, when en=1, drive the active color's output to 0 iff pwm_ctr < level, with red active in R_*, green in G_*, blue in B_*; the two inactive outputs stay 1.
REQ-018 SHALL register the outputs, so each output reflects the pwm_ctr, level and state values from the previous cycle (one-cycle latency).
REQ-019 SHALL produce an output that never goes to 0 at level=0, and is 0 for MAX of every 2^PWM_BITS cycles at level=MAX.
REQ-020 SHALL, when en=0, drive RGB0=RGB1=RGB2=1 from the next cycle, and hold level and state unchanged.
REQ-021 SHALL, when en returns to 1, resume from the frozen level and state with no reinitialisation.
REQ-022 SHALL, when tick and a falling en coincide (en=0 in that cycle), ignore the tick.

Reset
REQ-023 SHALL, on the clk edge where rst=0, set pwm_ctr=0, level=0, state=R_UP, RGB0=RGB1=RGB2=1 and cycle_done=0.
REQ-024 SHALL give reset priority over tick and en, and SHALL make reset asserted mid-ramp discard all progress.
REQ-025 SHALL hold outputs at 1 while rst=0, and SHALL apply an initial-value assignment equal to the reset values for power-up without reset.

Verification
REQ-026 SHALL cover: rst=0 for 2 cycles, then en=1, no tick -> RGB0/1/2 stay 1 (level=0) for 1000 cycles; cycle_done stays 0.
REQ-027 SHALL cover: PWM_BITS=8, STEP=1, en=1, 128 ticks -> level=128, state R_UP; RGB0=0 for exactly 128 of each 256 cycles, and RGB1=RGB2=1 throughout.
REQ-028 SHALL cover: STEP=100, ticks from reset -> level 100, 200, then 255 with R_UP->R_DN; then 155, 55, then 0 with R_DN->G_UP.
REQ-029 SHALL cover: STEP=100, run 18 ticks from reset -> cycle_done is high for exactly one cycle, after the 18th tick, and state=R_UP with level=0.
REQ-030 SHALL cover: en=0 with ticks asserted for 50 cycles at level=40 -> all outputs 1, level stays 40; after en=1, RGB0 duty is 40/256.
REQ-031 SHALL cover: rst=0 during G_DN at level=77 -> next cycle all outputs 1, state R_UP, level 0; a tick coinciding with rst=0 has no effect.
